// File: rtl/verificador_disparo.sv
// Shot checker for the 5x7 battleship map: snapshots the map, evaluates shots, tracks hits/budget/end.
// Optional build macro REPETIDO_CONSOME_EN: repeated shots also consume one shot from the budget.
module verificador_disparo #(
  parameter int MAX_TIROS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic       disparar,
  output logic       acerto,
  output logic       erro,
  output logic       repetido,
  output logic       invalido,
  output logic [5:0] tiros_restantes,
  output logic [5:0] acertos,
  output logic       vitoria,
  output logic       derrota,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    AGUARDA  = 2'd1,
    VERIFICA = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [5:0] TIROS_INI = 6'(MAX_TIROS);

  estado_t     estado_q, estado_n;
  logic [34:0] mapa_q, mapa_n;
  logic [34:0] mascara_q, mascara_n;
  logic [5:0]  total_q, total_n;
  logic [5:0]  tiros_q, tiros_n;
  logic [5:0]  acertos_q, acertos_n;
  logic [2:0]  linha_q, linha_n;
  logic [2:0]  coluna_q, coluna_n;
  logic        disparar_d;
  logic        acerto_q, acerto_n;
  logic        erro_q, erro_n;
  logic        repetido_q, repetido_n;
  logic        invalido_q, invalido_n;
  logic        vitoria_q, vitoria_n;
  logic        derrota_q, derrota_n;
  logic        evento_disparo;
  logic [34:0] mapa_entrada;
  logic [5:0]  idx;

  function automatic logic [5:0] contar_navios(input logic [34:0] m);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 35; i++) n = n + {5'b0, m[i]};
    return n;
  endfunction

  // Cell (r,c) lives at bit r*7 + (6-c), matching the row encoding of mapa0..mapa4.
  assign mapa_entrada   = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign idx            = {3'b0, linha_q} * 6'd7 + 6'd6 - {3'b0, coluna_q};
  assign evento_disparo = disparar & ~disparar_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
    estado_n   = estado_q;
    mapa_n     = mapa_q;
    mascara_n  = mascara_q;
    total_n    = total_q;
    tiros_n    = tiros_q;
    acertos_n  = acertos_q;
    linha_n    = linha_q;
    coluna_n   = coluna_q;
    acerto_n   = acerto_q;
    erro_n     = erro_q;
    repetido_n = repetido_q;
    invalido_n = invalido_q;
    vitoria_n  = vitoria_q;
    derrota_n  = derrota_q;

    if (iniciar) begin
      mapa_n     = mapa_entrada;
      mascara_n  = '0;
      total_n    = contar_navios(mapa_entrada);
      tiros_n    = TIROS_INI;
      acertos_n  = '0;
      acerto_n   = 1'b0;
      erro_n     = 1'b0;
      repetido_n = 1'b0;
      invalido_n = 1'b0;
      derrota_n  = 1'b0;
      vitoria_n  = (total_n == 6'd0);
      estado_n   = (total_n == 6'd0) ? FIM : AGUARDA;
    end else begin
      case (estado_q)
        AGUARDA: begin
          if (evento_disparo) begin
            linha_n  = linha;
            coluna_n = coluna;
            estado_n = VERIFICA;
          end
        end
        VERIFICA: begin
          acerto_n   = 1'b0;
          erro_n     = 1'b0;
          repetido_n = 1'b0;
          invalido_n = 1'b0;
          if (linha_q > 3'd4 || coluna_q > 3'd6) begin
            invalido_n = 1'b1;
          end else if (mascara_q[idx]) begin
            repetido_n = 1'b1;
`ifdef REPETIDO_CONSOME_EN
            tiros_n    = tiros_q - 6'd1;
`endif
          end else begin
            mascara_n[idx] = 1'b1;
            tiros_n        = tiros_q - 6'd1;
            if (mapa_q[idx]) begin
              acerto_n  = 1'b1;
              acertos_n = acertos_q + 6'd1;
            end else begin
              erro_n = 1'b1;
            end
          end
          // Victory is tested first so a final hit on the last shot is a win.
          if (acertos_n == total_q) begin
            estado_n  = FIM;
            vitoria_n = 1'b1;
          end else if (tiros_n == 6'd0) begin
            estado_n  = FIM;
            derrota_n = 1'b1;
          end else begin
            estado_n = AGUARDA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the map copy and shot mask are plain flops, so reset clears them like any other state.
      estado_q   <= OCIOSO;
      mapa_q     <= '0;
      mascara_q  <= '0;
      total_q    <= '0;
      tiros_q    <= '0;
      acertos_q  <= '0;
      linha_q    <= '0;
      coluna_q   <= '0;
      disparar_d <= 1'b0;
      acerto_q   <= 1'b0;
      erro_q     <= 1'b0;
      repetido_q <= 1'b0;
      invalido_q <= 1'b0;
      vitoria_q  <= 1'b0;
      derrota_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      estado_q   <= estado_n;
      mapa_q     <= mapa_n;
      mascara_q  <= mascara_n;
      total_q    <= total_n;
      tiros_q    <= tiros_n;
      acertos_q  <= acertos_n;
      linha_q    <= linha_n;
      coluna_q   <= coluna_n;
      disparar_d <= disparar;
      acerto_q   <= acerto_n;
      erro_q     <= erro_n;
      repetido_q <= repetido_n;
      invalido_q <= invalido_n;
      vitoria_q  <= vitoria_n;
      derrota_q  <= derrota_n;
    end
  end

  assign acerto          = acerto_q;
  assign erro            = erro_q;
  assign repetido        = repetido_q;
  assign invalido        = invalido_q;
  assign tiros_restantes = tiros_q;
  assign acertos         = acertos_q;
  assign vitoria         = vitoria_q;
  assign derrota         = derrota_q;
  assign estado          = estado_q;

endmodule

// File: doc/verificador_disparo.md
Name: verificador_disparo

Overview:
- Game-play consumer of the confirmed 5x7 map (mapa0..mapa4) produced by the map selector.
- On iniciar, snapshots the map, counts ship cells and arms a shot budget.
- Evaluates player shots (linha/coluna), flags hit/miss/repeat/invalid, and tracks hits, remaining shots and game end (victory/defeat) for the display and control logic.

Parameters:
MAX_TIROS, 15, shot budget per game; legal range 1..63.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset
iniciar  input  1  level; high at a clock edge starts or restarts a game
mapa0..mapa4  input  7 each  confirmed map rows 0..4; bit (6-c) = column c; 1 = ship
linha  input  3  shot row, valid 0..4
coluna  input  3  shot column, valid 0..6
disparar  input  1  fire request; rising edge detected internally
acerto  output  1  last evaluated shot hit a ship
erro  output  1  last evaluated shot was water
repetido  output  1  last shot targeted an already-shot cell
invalido  output  1  last shot coordinates out of range
tiros_restantes  output  6  shots left
acertos  output  6  ship cells hit so far
vitoria  output  1  all ship cells hit
derrota  output  1  budget exhausted with ships remaining
estado  output  2  FSM state: 0 OCIOSO, 1 AGUARDA, 2 VERIFICA, 3 FIM

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at clock edge) forces:
  - all outputs 0; estado=OCIOSO.
  - internal map copy, shot mask (35 bits), total_navios and disparar_d cleared.
- Reset has priority over everything.
- iniciar=1 at any clock edge, any state, with reset inactive:
  - copy mapa0..4 into internal map; shot mask=0; acertos=0; tiros_restantes=MAX_TIROS; all result flags=0.
  - total_navios = popcount of the 35 map bits.
  - If total_navios==0, go to FIM with vitoria=1. Otherwise go to AGUARDA.
  - A shot pending in VERIFICA is discarded.
  - Map inputs are ignored outside this cycle.
- Edge detect: disparar_d <= disparar every cycle. Fire event = disparar & ~disparar_d.
- AGUARDA:
  - On a fire event with iniciar=0, latch linha/coluna and go to VERIFICA.
  - Result flags keep their previous values until the next evaluation.
- VERIFICA (exactly 1 cycle). Exactly one of the four flags is set; the other three are cleared.
  - Invalid (linha>4 or coluna>6): invalido=1; no counter change.
  - Repeat (mask bit already set): repetido=1; no counter change.
  - Otherwise: set mask bit; tiros_restantes-1; then
    - ship bit 1: acerto=1, acertos+1.
    - ship bit 0: erro=1.
  - Next state, using post-update values:
    - acertos==total_navios: FIM, vitoria=1.
    - else tiros_restantes==0: FIM, derrota=1.
    - else AGUARDA.
  - Victory wins over defeat when the last shot is also the final hit.
- Latency: fire event sampled at edge N; VERIFICA during cycle N..N+1; flags and counters valid after edge N+1.
- FIM: fire events ignored; counters, flags, vitoria and derrota held; only iniciar or reset leaves.
- OCIOSO: fire events ignored.
- disparar held high: only one evaluation; it must drop low and rise again.
- vitoria and derrota are never both 1.
- Counters never wrap. tiros_restantes never decrements below 0, because FIM is entered at 0.

Optional Feature:
REPETIDO_CONSOME_EN
- Defined: a repeated shot sets repetido=1 and also decrements tiros_restantes. The next-state rule applies, so this can cause derrota.
- Undefined: repeated shots are free, as described above.
- Invalid shots never consume a shot in either build.

Test Plan:
- Basic hit/miss. Reset, then iniciar with mapa0..4 = 0000100, 0001100, 1000101, 1110001, 1000011 (13 ships), MAX_TIROS=15 -> estado=1, tiros_restantes=15, acertos=0.
  - Fire (0,4) -> acerto=1, acertos=1, tiros_restantes=14, 2 edges after sampling.
  - Fire (0,0) -> erro=1, tiros_restantes=13.
- Invalid and repeat, same map. Fire (5,2) -> invalido=1, counters unchanged.
  - Fire (0,4) twice -> second gives repetido=1; tiros_restantes drops by 1 total (by 2 with REPETIDO_CONSOME_EN).
  - Hold disparar high 10 cycles -> single evaluation.
- Victory on last shot. MAX_TIROS=13, same map; fire all 13 ship cells -> after the 13th: vitoria=1, derrota=0, tiros_restantes=0, acertos=13, estado=3.
  - Further fire events -> no change.
- Defeat. MAX_TIROS=15; fire 15 distinct water cells -> derrota=1, vitoria=0, acertos=0, estado=3.
- Empty map and restart. iniciar with all-zero map -> estado=3, vitoria=1 one edge later.
  - Then iniciar with the 13-ship map while in FIM -> estado=1, flags 0, tiros_restantes=15.
- Reset mid-game. rst_n=0 for one edge while estado=2 -> all outputs 0, estado=0, shot not counted.
